player_move: RTL and testbench
==============================

# player_move

Per-player movement controller sitting directly downstream of the PS/2 keyboard decoder. It consumes the held-key levels for one player (`up`/`down`/`left`/`right`/`drop`) plus the game-state levels, and advances the player's pixel position once per video frame on a tile grid. Before entering a new tile it asks the map block whether that tile is blocked. It also emits one-cycle bomb-drop requests toward the bomb manager. There is one instance per player.

## Interface
- `TILE`, 32: tile size in pixels; must be a power of two.
- `GRID_W`, 13: grid width in tiles.
- `GRID_H`, 11: grid height in tiles.
- `START_TX`, 1: reset/new-game tile column.
- `START_TY`, 1: reset/new-game tile row.
- `SPEED`, 2: pixels moved per frame; must divide `TILE`.

Ports:
- `clk` in 1: system clock. This is the single clock.
- `reset` in 1: synchronous, active-high reset.
- `up`, `down`, `left`, `right` in 1 each: held-key levels from the keyboard decoder.
- `drop` in 1: held drop-key level.
- `game_over` in 1: level; while high the player is frozen.
- `new_game` in 1: level; a rising edge returns the player to the start tile.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `query_req` out 1: tile-blocked query request.
- `query_tx` out 4: tile column being queried.
- `query_ty` out 4: tile row being queried.
- `query_ack` in 1: query answered; `query_blocked` is valid in the same cycle.
- `query_blocked` in 1: 1 = target tile is a wall, brick or bomb.
- `pos_x`, `pos_y` out 9 each: top-left pixel of the sprite.
- `facing` out 2: 0 = up, 1 = down, 2 = left, 3 = right.
- `moving` out 1: high while a step is in progress (used for sprite animation).
- `bomb_drop` out 1: one-cycle bomb request.
- `bomb_tx`, `bomb_ty` out 4 each: bomb tile; valid while `bomb_drop` is high.

## Operation
- Reset values:
  - `pos_x` = `START_TX*TILE`, `pos_y` = `START_TY*TILE`.
  - `facing` = 1, `moving` = 0.
  - `query_req` = 0, `bomb_drop` = 0, `query_tx` = `query_ty` = 0, `bomb_tx` = `bomb_ty` = 0.
  - FSM in IDLE.
  - Edge detectors for `drop` and `new_game` are cleared to 0.
- "Aligned" means both `pos_x` and `pos_y` are multiples of `TILE`. The current tile is `pos >> log2(TILE)`.
- FSM states: IDLE, QUERY, STEP.
- IDLE, on `frame_tick` with `game_over` = 0:
  - Not aligned: go to STEP and keep the current `facing` (a started move is always completed to the next tile).
  - Aligned with at least one direction held: choose by priority up > down > left > right and set `facing` to it.
    - Target tile outside 0..`GRID_W-1` / 0..`GRID_H-1`: blocked; stay in IDLE with `moving` = 0.
    - Otherwise: drive `query_tx`/`query_ty` with the target tile, raise `query_req`, go to QUERY.
  - Aligned with no direction held: stay in IDLE with `moving` = 0.
- QUERY:
  - Hold `query_req` and the query coordinates stable until `query_ack` is seen.
  - On ack: drop `query_req` in the next cycle.
  - `query_blocked` = 1: return to IDLE with `moving` = 0.
  - `query_blocked` = 0: go to STEP.
- STEP:
  - Add or subtract `SPEED` on the axis given by `facing`, set `moving` = 1, return to IDLE.
  - Coordinates never go below 0 or past `(GRID-1)*TILE`.
- `frame_tick` pulses arriving while in QUERY or STEP are ignored, not queued.
- Drop handling:
  - A rising edge of `drop` (registered previous value 0, current 1) with `game_over` = 0 gives `bomb_drop` = 1 for exactly one cycle.
  - `bomb_tx` = `(pos_x + TILE/2) >> log2(TILE)`, i.e. the nearest tile. `bomb_ty` is computed the same way from `pos_y`.
  - Holding `drop` produces only one pulse. Bomb drops are independent of the FSM state.
- `new_game` rising edge:
  - Synchronous soft reset of position, `facing` and FSM, to the same values as `reset`.
  - Any pending `query_req` is dropped in the next cycle.
  - It takes priority over a `frame_tick` in the same cycle.
- `game_over` high:
  - Position is frozen, `frame_tick` is ignored and `moving` = 0.
  - A query already in progress still completes; if its answer is "free", the STEP is skipped.

## Timing
- `frame_tick` (cycle t) in IDLE while aligned: `query_req` is high at t+1.
- `query_ack` at cycle a: state is STEP at a+1, new position is visible at a+2, `query_req` is low from a+1.
- Unaligned `frame_tick` at t: new position at t+2.
- `drop` rising edge sampled at cycle d: `bomb_drop` is high at d+1 only.
- There is no combinational path from any input to any output; all outputs are registered.
- `reset` overrides everything, including an in-flight query.

## Test plan
- **Reset:** assert `reset` for 2 cycles with defaults -> `pos_x` = 32, `pos_y` = 32, `facing` = 1, `query_req` = 0, `bomb_drop` = 0.
- **Free move:** hold `right`, pulse `frame_tick`, ack with `query_blocked` = 0 -> `query_tx` = 2, `query_ty` = 1, then `pos_x` = 34. Fifteen further ticks, with no queries issued, -> `pos_x` = 64. The next tick issues a query for `query_tx` = 3.
- **Blocked move:** at tile (1,1) hold `up`, ack with `query_blocked` = 1 -> `pos_y` stays 32, `facing` = 0, `moving` = 0.
- **Grid edge:** at tile (0,0) hold `left` and tick -> no `query_req` at all, position unchanged, `facing` = 2.
- **Priority and mid-tile release:** hold `up` and `right` together -> query targets (1,0). After one free step, release all keys -> movement continues until `pos_y` = 0.
- **Bomb and game state:**
  - Hold `drop` for 10 cycles at `pos_x` = 50, `pos_y` = 32 -> a single `bomb_drop` pulse with `bomb_tx` = 2, `bomb_ty` = 1.
  - With `game_over` = 1, ticks do not change the position.
  - A `new_game` rising edge -> position returns to (32, 32).

Source files
------------

// File: rtl/player_move.sv
// rtl/player_move.sv - per-player tile-grid movement controller with bomb-drop requests
//
// Advances one player's sprite position by SPEED pixels per frame_tick. A step into
// a new tile first asks the map block (query_req/query_ack) whether that tile is blocked.
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   up, down, left, right, drop held-key levels from the keyboard decoder
//   game_over, new_game         game-state levels (freeze / rising-edge restart)
//   frame_tick                  one-cycle pulse per video frame
//   query_req, query_tx/ty      tile-blocked query toward the map block
//   query_ack, query_blocked    query answer, valid together
//   pos_x, pos_y                sprite top-left pixel
//   facing, moving              direction (0 up, 1 down, 2 left, 3 right) and step activity
//   bomb_drop, bomb_tx/ty       one-cycle bomb request with its nearest tile
module player_move #(
    parameter int TILE     = 32,
    parameter int GRID_W   = 13,
    parameter int GRID_H   = 11,
    parameter int START_TX = 1,
    parameter int START_TY = 1,
    parameter int SPEED    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       drop,
    input  logic       game_over,
    input  logic       new_game,
    input  logic       frame_tick,
    output logic       query_req,
    output logic [3:0] query_tx,
    output logic [3:0] query_ty,
    input  logic       query_ack,
    input  logic       query_blocked,
    output logic [8:0] pos_x,
    output logic [8:0] pos_y,
    output logic [1:0] facing,
    output logic       moving,
    output logic       bomb_drop,
    output logic [3:0] bomb_tx,
    output logic [3:0] bomb_ty
);

    localparam int         SHIFT      = $clog2(TILE);
    localparam logic [8:0] START_X    = 9'(START_TX * TILE);
    localparam logic [8:0] START_Y    = 9'(START_TY * TILE);
    localparam logic [8:0] MAX_X      = 9'((GRID_W - 1) * TILE);
    localparam logic [8:0] MAX_Y      = 9'((GRID_H - 1) * TILE);
    localparam logic [8:0] STEP_PX    = 9'(SPEED);
    localparam logic [8:0] ALIGN_MASK = 9'(TILE - 1);
    localparam logic [3:0] LAST_TX    = 4'(GRID_W - 1);
    localparam logic [3:0] LAST_TY    = 4'(GRID_H - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {IDLE, QUERY, STEP} state_t;

    state_t     state;
    logic       drop_q;
    logic       new_game_q;

    logic       aligned;
    logic [3:0] cur_tx;
    logic [3:0] cur_ty;
    logic       drop_rise;
    logic       new_game_rise;
    logic [9:0] centre_x;
    logic [9:0] centre_y;

    logic       key_held;
    logic [1:0] key_dir;
    logic [3:0] tgt_tx;
    logic [3:0] tgt_ty;
    logic       tgt_ok;

    assign aligned       = ((pos_x & ALIGN_MASK) == 9'd0) && ((pos_y & ALIGN_MASK) == 9'd0);
    assign cur_tx        = 4'(pos_x >> SHIFT);
    assign cur_ty        = 4'(pos_y >> SHIFT);
    assign drop_rise     = drop && !drop_q && !game_over;
    assign new_game_rise = new_game && !new_game_q;
    // Half a tile of bias turns the truncating shift into nearest-tile rounding.
    assign centre_x      = {1'b0, pos_x} + 10'(TILE / 2);
    assign centre_y      = {1'b0, pos_y} + 10'(TILE / 2);

    // Direction priority up > down > left > right, and the neighbour tile it targets.
    // tgt_ok is low when that neighbour lies outside the grid.
    always_comb begin
        key_held = up || down || left || right;
        key_dir  = DIR_RIGHT;
        tgt_tx   = cur_tx;
        tgt_ty   = cur_ty;
        tgt_ok   = 1'b0;
        if (up) begin
            key_dir = DIR_UP;
            tgt_ty  = cur_ty - 4'd1;
            tgt_ok  = (cur_ty != 4'd0);
        end else if (down) begin
            key_dir = DIR_DOWN;
            tgt_ty  = cur_ty + 4'd1;
            tgt_ok  = (cur_ty != LAST_TY);
        end else if (left) begin
            key_dir = DIR_LEFT;
            tgt_tx  = cur_tx - 4'd1;
            tgt_ok  = (cur_tx != 4'd0);
        end else if (right) begin
            key_dir = DIR_RIGHT;
            tgt_tx  = cur_tx + 4'd1;
            tgt_ok  = (cur_tx != LAST_TX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pos_x      <= START_X;
            pos_y      <= START_Y;
            facing     <= DIR_DOWN;
            moving     <= 1'b0;
            query_req  <= 1'b0;
            query_tx   <= 4'd0;
            query_ty   <= 4'd0;
            bomb_drop  <= 1'b0;
            bomb_tx    <= 4'd0;
            bomb_ty    <= 4'd0;
            drop_q     <= 1'b0;
            new_game_q <= 1'b0;
        end else begin
            drop_q     <= drop;
            new_game_q <= new_game;

            // Bomb requests run independently of the movement FSM.
            bomb_drop <= drop_rise;
            if (drop_rise) begin
                bomb_tx <= 4'(centre_x >> SHIFT);
                bomb_ty <= 4'(centre_y >> SHIFT);
            end

            if (new_game_rise) begin
                state     <= IDLE;
                pos_x     <= START_X;
                pos_y     <= START_Y;
                facing    <= DIR_DOWN;
                moving    <= 1'b0;
                query_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (game_over) begin
                            moving <= 1'b0;
                        end else if (frame_tick) begin
                            if (!aligned) begin
                                // A started move always finishes on the next tile.
                                state <= STEP;
                            end else if (key_held) begin
                                facing <= key_dir;
                                if (tgt_ok) begin
                                    query_tx  <= tgt_tx;
                                    query_ty  <= tgt_ty;
                                    query_req <= 1'b1;
                                    state     <= QUERY;
                                end else begin
                                    moving <= 1'b0;
                                end
                            end else begin
                                moving <= 1'b0;
                            end
                        end
                    end
                    QUERY: begin
                        if (query_ack) begin
                            query_req <= 1'b0;
                            // A free answer that lands during game_over is discarded.
                            if (query_blocked || game_over) begin
                                moving <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                state <= STEP;
                            end
                        end
                    end
                    STEP: begin
                        state <= IDLE;
                        if (game_over) begin
                            moving <= 1'b0;
                        end else begin
                            moving <= 1'b1;
                            case (facing)
                                DIR_UP:    pos_y <= (pos_y < STEP_PX) ? 9'd0 : pos_y - STEP_PX;
                                DIR_DOWN:  pos_y <= (pos_y >= MAX_Y - STEP_PX) ? MAX_Y : pos_y + STEP_PX;
                                DIR_LEFT:  pos_x <= (pos_x < STEP_PX) ? 9'd0 : pos_x - STEP_PX;
                                DIR_RIGHT: pos_x <= (pos_x >= MAX_X - STEP_PX) ? MAX_X : pos_x + STEP_PX;
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_move.sv
// tb/tb_player_move.sv - scoreboard bench for player_move
module tb_player_move;

    logic       clk = 1'b0;
    logic       reset;
    logic       up, down, left, right, drop;
    logic       game_over, new_game, frame_tick;
    logic       query_req;
    logic [3:0] query_tx, query_ty;
    logic       query_ack, query_blocked;
    logic [8:0] pos_x, pos_y;
    logic [1:0] facing;
    logic       moving;
    logic       bomb_drop;
    logic [3:0] bomb_tx, bomb_ty;

    player_move dut (
        .clk           (clk),
        .reset         (reset),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .drop          (drop),
        .game_over     (game_over),
        .new_game      (new_game),
        .frame_tick    (frame_tick),
        .query_req     (query_req),
        .query_tx      (query_tx),
        .query_ty      (query_ty),
        .query_ack     (query_ack),
        .query_blocked (query_blocked),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .facing        (facing),
        .moving        (moving),
        .bomb_drop     (bomb_drop),
        .bomb_tx       (bomb_tx),
        .bomb_ty       (bomb_ty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  exp_query[$];
    logic [7:0]  exp_bomb[$];
    logic [19:0] exp_pos[$];

    logic        mon_en = 1'b0;
    logic        q_prev;
    logic [19:0] pos_prev;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void push_query(input int tx, input int ty);
        exp_query.push_back({4'(tx), 4'(ty)});
    endfunction

    function automatic void push_bomb(input int tx, input int ty);
        exp_bomb.push_back({4'(tx), 4'(ty)});
    endfunction

    function automatic void push_pos(input int x, input int y, input int f);
        exp_pos.push_back({9'(x), 9'(y), 2'(f)});
    endfunction

    // Monitor: every new query, every bomb pulse cycle and every change of
    // (pos_x, pos_y, facing) consumes one expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (query_req && !q_prev) begin
                check("query_expected", int'(exp_query.size() != 0), 1);
                if (exp_query.size() != 0) begin
                    logic [7:0] e;
                    e = exp_query.pop_front();
                    check("query_tx", int'(query_tx), int'(e[7:4]));
                    check("query_ty", int'(query_ty), int'(e[3:0]));
                end
            end
            q_prev = query_req;

            if (bomb_drop) begin
                check("bomb_expected", int'(exp_bomb.size() != 0), 1);
                if (exp_bomb.size() != 0) begin
                    logic [7:0] e;
                    e = exp_bomb.pop_front();
                    check("bomb_tx", int'(bomb_tx), int'(e[7:4]));
                    check("bomb_ty", int'(bomb_ty), int'(e[3:0]));
                end
            end

            if ({pos_x, pos_y, facing} != pos_prev) begin
                check("pos_change_expected", int'(exp_pos.size() != 0), 1);
                if (exp_pos.size() != 0) begin
                    logic [19:0] e;
                    e = exp_pos.pop_front();
                    n_checks++;
                    if ({pos_x, pos_y, facing} == e) n_pass++;
                    else $display("FAIL pos_facing: got (%0d,%0d,f%0d) expected (%0d,%0d,f%0d)",
                                  pos_x, pos_y, facing, e[19:11], e[10:2], e[1:0]);
                end
            end
            pos_prev = {pos_x, pos_y, facing};
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_once();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    task automatic walk(input int n);
        repeat (n) begin
            tick_once();
            cyc(3);
        end
    endtask

    // Called right after a tick that should have raised a query.
    task automatic query_handshake(input logic blk);
        check("query_req_next_cycle", int'(query_req), 1);
        // A tick during QUERY must be ignored and the request must hold.
        tick_once();
        check("query_req_held", int'(query_req), 1);
        query_ack     = 1'b1;
        query_blocked = blk;
        cyc(1);
        query_ack     = 1'b0;
        query_blocked = 1'b0;
        check("query_req_dropped", int'(query_req), 0);
        cyc(3);
    endtask

    initial begin
        reset = 1'b1;
        {up, down, left, right, drop} = '0;
        game_over = 1'b0; new_game = 1'b0; frame_tick = 1'b0;
        query_ack = 1'b0; query_blocked = 1'b0;
        cyc(2);
        reset = 1'b0;

        check("reset_pos_x", int'(pos_x), 32);
        check("reset_pos_y", int'(pos_y), 32);
        check("reset_facing", int'(facing), 1);
        check("reset_moving", int'(moving), 0);
        check("reset_query_req", int'(query_req), 0);
        check("reset_bomb_drop", int'(bomb_drop), 0);

        q_prev   = 1'b0;
        pos_prev = {9'd32, 9'd32, 2'd1};
        mon_en   = 1'b1;

        // Blocked move up from (1,1).
        push_query(1, 0); push_pos(32, 32, 0);
        up = 1'b1; tick_once(); query_handshake(1'b1); up = 1'b0;
        check("blocked_moving", int'(moving), 0);

        // Free move right, then walk to the next tile.
        push_query(2, 1); push_pos(32, 32, 3); push_pos(34, 32, 3);
        right = 1'b1; tick_once(); query_handshake(1'b0);
        for (int i = 1; i <= 15; i++) push_pos(34 + 2 * i, 32, 3);
        walk(15);
        push_query(3, 1);
        tick_once(); query_handshake(1'b1); right = 1'b0;
        check("blocked_right_moving", int'(moving), 0);

        // Soft restart back to (1,1).
        push_pos(32, 32, 1);
        new_game = 1'b1; cyc(2); new_game = 1'b0; cyc(1);

        // Up beats right; keys released mid-tile, motion completes.
        push_query(1, 0); push_pos(32, 32, 0); push_pos(32, 30, 0);
        up = 1'b1; right = 1'b1; tick_once(); query_handshake(1'b0);
        up = 1'b0; right = 1'b0;
        for (int i = 1; i <= 15; i++) push_pos(32, 30 - 2 * i, 0);
        walk(15);

        // Walk left to (0,0).
        push_query(0, 0); push_pos(32, 0, 2); push_pos(30, 0, 2);
        left = 1'b1; tick_once(); query_handshake(1'b0); left = 1'b0;
        for (int i = 1; i <= 15; i++) push_pos(30 - 2 * i, 0, 2);
        walk(15);

        // Grid edges: no query, only facing changes.
        push_pos(0, 0, 0);
        up = 1'b1; tick_once(); cyc(3); up = 1'b0;
        push_pos(0, 0, 2);
        left = 1'b1; tick_once();
        check("edge_no_query", int'(query_req), 0);
        cyc(3); left = 1'b0;
        check("edge_moving", int'(moving), 0);

        // Restart, then walk to pos_x = 50.
        push_pos(32, 32, 1);
        new_game = 1'b1; cyc(2); new_game = 1'b0; cyc(1);
        push_query(2, 1); push_pos(32, 32, 3); push_pos(34, 32, 3);
        right = 1'b1; tick_once(); query_handshake(1'b0); right = 1'b0;
        for (int i = 1; i <= 8; i++) push_pos(34 + 2 * i, 32, 3);
        walk(8);

        // Held drop gives a single bomb pulse at the nearest tile.
        push_bomb(2, 1);
        drop = 1'b1; cyc(10); drop = 1'b0; cyc(2);

        // game_over freezes position and suppresses drops.
        game_over = 1'b1; cyc(1);
        walk(3);
        check("game_over_moving", int'(moving), 0);
        drop = 1'b1; cyc(3); drop = 1'b0; cyc(1);
        game_over = 1'b0; cyc(1);

        // new_game rise wins over a simultaneous frame_tick.
        push_pos(32, 32, 1);
        new_game = 1'b1; frame_tick = 1'b1; cyc(1);
        frame_tick = 1'b0; cyc(3);
        new_game = 1'b0; cyc(5);

        check("query_queue_empty", exp_query.size(), 0);
        check("bomb_queue_empty", exp_bomb.size(), 0);
        check("pos_queue_empty", exp_pos.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
